alu_issue_ctrl: RTL
===================

Name: alu_issue_ctrl

Overview:
Upstream issue stage for the 16-bit combinational ALU. It holds an 8-entry x 16-bit register file and accepts 16-bit register-to-register instructions over a valid/ready handshake. For each instruction it reads two source registers and drives the ALU's opcode and operand inputs from registers. It then captures the ALU result, writes it back to the destination register and presents it on a result handshake.

Parameters:
- WIDTH, 16, datapath and ALU operand width
- NREGS, 8, register file depth (address width = log2(NREGS) = 3)

Ports:
- clock  in  1  system clock, all state updates on posedge
- clear  in  1  synchronous active-low reset; sampled on posedge clock
- load_en  in  1  host register preload strobe
- load_addr  in  3  preload destination register
- load_data  in  WIDTH  preload value
- in_valid  in  1  instruction offered
- in_ready  out  1  block accepts instruction this cycle
- in_instr  in  16  [15:14] op, [13:11] rd, [10:8] rs1, [7:5] rs2, [4:0] ignored
- alu_op  out  2  opCode to ALU (registered)
- alu_a  out  WIDTH  inputA to ALU (registered)
- alu_b  out  WIDTH  inputB to ALU (registered)
- alu_result  in  WIDTH  result from ALU (combinational)
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out_data  out  WIDTH  captured result
- out_rd  out  3  destination register of out_data

Behaviour:
- Reset: clear=0 at posedge forces state IDLE, all NREGS registers to 0, alu_op=0, alu_a=0, alu_b=0, out_data=0, out_rd=0, out_valid=0. in_ready=0 while clear=0.
- Reset mid-operation aborts the operation. No writeback occurs and no out_valid is produced.
- ALU op encoding: 00 = A+B, 01 = A-B, 10 = ~A, 11 = reserved. The block does not interpret op and forwards all four codes unchanged.
- Arithmetic is the ALU's; WIDTH bits with wrap-around. The block adds no carry or overflow handling.
- in_ready = (state==IDLE) & ~load_en. Load has priority over instruction accept in the same cycle.
- Preload: load_en=1 in IDLE writes load_data to regs[load_addr] at posedge. load_en outside IDLE is ignored (no write).
- FSM:
  - IDLE: on in_valid & in_ready, latch op to alu_op, regs[rs1] to alu_a, regs[rs2] to alu_b, and rd internally; go to OPER.
  - OPER: for one cycle, ALU operands are stable. At the posedge, out_data <= alu_result, regs[rd] <= alu_result, out_rd <= rd, out_valid <= 1; go to DONE.
  - DONE: hold out_valid, out_data and out_rd. On out_ready=1, out_valid <= 0 and go to IDLE.
- Latency: instruction accepted at edge N. ALU inputs are valid in cycle N+1. Writeback and out_valid are visible after edge N+2.
- Throughput: at most one instruction per 3 cycles. It is lower under backpressure.
- rs1, rs2 and rd may alias. Sources are read at accept, before writeback, so rd=rs1=rs2 is well defined.
- alu_op, alu_a and alu_b retain their last values in IDLE and DONE.
- Back-to-back dependency (the next instruction reads the previous rd) sees the written value, because writeback precedes the return to IDLE.
- The instruction word must be held stable by the source only until accept; the block latches all fields.

Decomposition:
- Shared package alu_pkg holds:
  - op constants (OP_ADD=2'b00, OP_SUB=2'b01, OP_NOT=2'b10)
  - instruction field bit positions
  - FSM state encoding (IDLE, OPER, DONE)
- Sub-module alu_regfile: NREGS x WIDTH.
  - Two asynchronous read ports.
  - One synchronous write port, with a writeback/preload mux in the parent.
  - Synchronous active-low clear zeroes all entries.

Test Plan:
- Reset: hold clear=0 for 2 cycles with in_valid=1 -> in_ready=0, out_valid=0, all outputs 0. Read of any register via an ADD r0+r0 after reset -> out_data=0x0000.
- Add: preload r1=0x0325 and r2=0x012E; issue ADD rd=3, rs1=1, rs2=2 -> alu_op=00, alu_a=0x0325, alu_b=0x012E one cycle after accept; out_data=0x0453 (1107), out_rd=3, out_valid 2 cycles after accept.
- Sub and not: SUB r4=r1-r2 -> 0x01F7 (503). NOT r5=~r2 -> 0xFED1. Then ADD r6=r4+r4 -> 0x03EE, which confirms the dependency via writeback.
- Wrap: preload r1=0xFFFF and r2=0x0001; ADD -> 0x0000. SUB r2-r1 -> 0x0002.
- Backpressure: hold out_ready=0 for 5 cycles -> out_valid stays 1, out_data is stable and in_ready=0. A new in_valid is not accepted until the cycle after out_ready=1.
- Priority and abort:
  - load_en and in_valid together in IDLE -> load written, instruction not accepted that cycle.
  - clear=0 asserted in OPER -> no writeback to rd; out_valid remains 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: op codes, instruction field
// positions and the issue FSM state encoding.
package alu_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned OP_W    = 2;

  // Instruction layout: [15:14] op, [13:11] rd, [10:8] rs1, [7:5] rs2, [4:0] unused
  localparam int unsigned OP_LSB  = 14;
  localparam int unsigned RD_LSB  = 11;
  localparam int unsigned RS1_LSB = 8;
  localparam int unsigned RS2_LSB = 5;

  localparam logic [OP_W-1:0] OP_ADD  = 2'b00;
  localparam logic [OP_W-1:0] OP_SUB  = 2'b01;
  localparam logic [OP_W-1:0] OP_NOT  = 2'b10;
  localparam logic [OP_W-1:0] OP_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OPER = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_regfile.sv
// NREGS x WIDTH register file: two asynchronous read ports, one synchronous
// write port, synchronous active-low clear of every entry.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREGS = 8,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr1_i,
  input  logic [AW-1:0]    raddr2_i,
  output logic [WIDTH-1:0] rdata1_o,
  output logic [WIDTH-1:0] rdata2_o
);

  logic [WIDTH-1:0] regs_q [NREGS];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = regs_q[raddr1_i];
  assign rdata2_o = regs_q[raddr2_i];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue stage for the 16-bit combinational ALU: reads two sources, drives
// registered ALU operands, captures the result, writes it back and returns it.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREGS = 8
) (
  input  logic                     clock,
  input  logic                     clear,
  input  logic                     load_en,
  input  logic [$clog2(NREGS)-1:0] load_addr,
  input  logic [WIDTH-1:0]         load_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [INSTR_W-1:0]       in_instr,
  output logic [OP_W-1:0]          alu_op,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  input  logic [WIDTH-1:0]         alu_result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(NREGS)-1:0] out_rd
);

  localparam int unsigned AW = $clog2(NREGS);

  state_e           state_q;
  logic [OP_W-1:0]  alu_op_q;
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic [AW-1:0]    rd_q;
  logic [WIDTH-1:0] out_data_q;
  logic [AW-1:0]    out_rd_q;
  logic             out_valid_q;

  logic [OP_W-1:0]  instr_op;
  logic [AW-1:0]    instr_rd;
  logic [AW-1:0]    instr_rs1;
  logic [AW-1:0]    instr_rs2;
  logic             unused_instr;

  logic [WIDTH-1:0] rs1_data;
  logic [WIDTH-1:0] rs2_data;

  logic             wr_en_d;
  logic [AW-1:0]    wr_addr_d;
  logic [WIDTH-1:0] wr_data_d;

  logic             accept;

  assign instr_op     = in_instr[OP_LSB +: OP_W];
  assign instr_rd     = in_instr[RD_LSB +: AW];
  assign instr_rs1    = in_instr[RS1_LSB +: AW];
  assign instr_rs2    = in_instr[RS2_LSB +: AW];
  assign unused_instr = ^in_instr[RS2_LSB-1:0];

  // Load takes the IDLE cycle, so an offered instruction waits one cycle.
  assign in_ready = clear & (state_q == IDLE) & ~load_en;
  assign accept   = in_valid & in_ready;

  // Single write port shared by ALU writeback (OPER) and host preload (IDLE).
  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = load_addr;
    wr_data_d = load_data;
    if (state_q == OPER) begin
      wr_en_d   = 1'b1;
      wr_addr_d = rd_q;
      wr_data_d = alu_result;
    end else if (state_q == IDLE && load_en) begin
      wr_en_d = 1'b1;
    end
  end

  alu_regfile #(
    .WIDTH (WIDTH),
    .NREGS (NREGS),
    .AW    (AW)
  ) u_regfile (
    .clk_i    (clock),
    .rst_ni   (clear),
    .we_i     (wr_en_d),
    .waddr_i  (wr_addr_d),
    .wdata_i  (wr_data_d),
    .raddr1_i (instr_rs1),
    .raddr2_i (instr_rs2),
    .rdata1_o (rs1_data),
    .rdata2_o (rs2_data)
  );

  always_ff @(posedge clock) begin
    if (!clear) begin
      state_q     <= IDLE;
      alu_op_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      rd_q        <= '0;
      out_data_q  <= '0;
      out_rd_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            alu_op_q <= instr_op;
            alu_a_q  <= rs1_data;
            alu_b_q  <= rs2_data;
            rd_q     <= instr_rd;
            state_q  <= OPER;
          end
        end
        OPER: begin
          out_data_q  <= alu_result;
          out_rd_q    <= rd_q;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign alu_op    = alu_op_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_rd    = out_rd_q;

endmodule
